// File: rtl/braille_pkg.sv
// Shared letter-code constants, Braille dot-pattern encoder, seven-seg glyph table and
// cell-player FSM state encoding.
package braille_pkg;

    localparam int unsigned LETTER_W = 5;
    localparam logic [LETTER_W-1:0] LETTER_MAX = 5'd25;

    localparam logic [5:0] DOT3 = 6'b000100;
    localparam logic [5:0] DOT6 = 6'b100000;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } state_t;

    // Dots 1..6 map to bits 0..5; later decades reuse the a..j pattern plus dot3 (and dot6).
    function automatic logic [5:0] dot_pattern(input logic [LETTER_W-1:0] code);
        logic [3:0] base;
        logic [5:0] extra;
        logic [5:0] pat;
        base  = 4'd0;
        extra = 6'b000000;
        pat   = 6'b000000;
        if (code < 5'd10) begin
            base = code[3:0];
        end else if (code < 5'd20) begin
            base  = 4'(code - 5'd10);
            extra = DOT3;
        end else if (code < 5'd22) begin
            base  = 4'(code - 5'd20);
            extra = DOT3 | DOT6;
        end else if (code > 5'd22) begin
            base  = 4'(code - 5'd21);
            extra = DOT3 | DOT6;
        end
        case (base)
            4'd0:    pat = 6'b000001;
            4'd1:    pat = 6'b000011;
            4'd2:    pat = 6'b001001;
            4'd3:    pat = 6'b011001;
            4'd4:    pat = 6'b010001;
            4'd5:    pat = 6'b001011;
            4'd6:    pat = 6'b011011;
            4'd7:    pat = 6'b010011;
            4'd8:    pat = 6'b001010;
            4'd9:    pat = 6'b011010;
            default: pat = 6'b000000;
        endcase
        if (code == 5'd22) begin
            return 6'b111010;
        end
        return pat | extra;
    endfunction

    // Active-low {g,f,e,d,c,b,a} glyphs shared with the alphabet displays.
    function automatic logic [6:0] seg_glyph(input logic [LETTER_W-1:0] code);
        logic [6:0] g;
        case (code)
            5'd0:    g = 7'h08;
            5'd1:    g = 7'h03;
            5'd2:    g = 7'h46;
            5'd3:    g = 7'h21;
            5'd4:    g = 7'h06;
            5'd5:    g = 7'h0E;
            5'd6:    g = 7'h42;
            5'd7:    g = 7'h09;
            5'd8:    g = 7'h79;
            5'd9:    g = 7'h61;
            5'd10:   g = 7'h0A;
            5'd11:   g = 7'h47;
            5'd12:   g = 7'h6A;
            5'd13:   g = 7'h2B;
            5'd14:   g = 7'h40;
            5'd15:   g = 7'h0C;
            5'd16:   g = 7'h18;
            5'd17:   g = 7'h2F;
            5'd18:   g = 7'h12;
            5'd19:   g = 7'h07;
            5'd20:   g = 7'h41;
            5'd21:   g = 7'h63;
            5'd22:   g = 7'h55;
            5'd23:   g = 7'h36;
            5'd24:   g = 7'h11;
            5'd25:   g = 7'h24;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/braille_cell_player_fifo.sv
// Letter-code FIFO for the Braille cell player; extra pointer MSB distinguishes full from empty.
module braille_fifo
    import braille_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [LETTER_W-1:0] wdata,
    output logic [LETTER_W-1:0] rdata,
    output logic                full,
    output logic                empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]         wptr_q;
    logic [AW:0]         rptr_q;
    logic [LETTER_W-1:0] mem_q [DEPTH];
    logic                do_push;
    logic                do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/braille_cell_player.sv
// Buffers letter codes and plays each as a timed 6-dot Braille cell followed by a blank gap.
// Define BRAILLE_SEG_ECHO_EN to echo the playing letter on seg_letter.
module braille_cell_player
    import braille_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SHOW_TICKS = 2,
    parameter int unsigned GAP_TICKS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                load,
    input  logic [LETTER_W-1:0] letter,
    input  logic                clear,
    output logic [5:0]          dots,
    output logic                busy,
    output logic                full,
    output logic                err,
    output logic [6:0]          seg_letter
);

    localparam int unsigned MAX_TICKS = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

    state_t              state;
    logic [CW-1:0]       tick_cnt;
    logic                empty;
    logic                push;
    logic                pop;
    logic [LETTER_W-1:0] head;

    // full is the registered occupancy, so a push while full loses even against a same-cycle pop.
    assign push = load && !clear && !full && (letter <= LETTER_MAX);
    assign pop  = (state == StIdle) && !empty && !clear;
    assign busy = (state != StIdle) || !empty;

    braille_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .wdata (letter),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            tick_cnt <= '0;
            dots     <= 6'b000000;
            err      <= 1'b0;
        end else begin
            err <= load && !clear && ((letter > LETTER_MAX) || full);
            if (clear) begin
                state    <= StIdle;
                tick_cnt <= '0;
                dots     <= 6'b000000;
            end else begin
                case (state)
                    StIdle: begin
                        if (!empty) begin
                            state    <= StShow;
                            tick_cnt <= '0;
                            dots     <= dot_pattern(head);
                        end
                    end
                    StShow: begin
                        if (tick) begin
                            if (tick_cnt == SHOW_LAST) begin
                                state    <= StGap;
                                tick_cnt <= '0;
                                dots     <= 6'b000000;
                            end else begin
                                tick_cnt <= tick_cnt + CW'(1);
                            end
                        end
                    end
                    StGap: begin
                        if (tick) begin
                            if (tick_cnt == GAP_LAST) begin
                                state    <= StIdle;
                                tick_cnt <= '0;
                            end else begin
                                tick_cnt <= tick_cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= StIdle;
                        tick_cnt <= '0;
                        dots     <= 6'b000000;
                    end
                endcase
            end
        end
    end

`ifdef BRAILLE_SEG_ECHO_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            seg_letter <= 7'h7F;
        end else if (pop) begin
            seg_letter <= seg_glyph(head);
        end else if ((state == StShow) && tick && (tick_cnt == SHOW_LAST)) begin
            seg_letter <= 7'h7F;
        end
    end
`else
    assign seg_letter = 7'h7F;
`endif

endmodule

// File: tb/tb_braille_cell_player.sv
// Directed self-checking bench for braille_cell_player (default build, echo disabled).
module tb_braille_cell_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       load;
    logic [4:0] letter;
    logic       clear;
    logic [5:0] dots;
    logic       busy;
    logic       full;
    logic       err;
    logic [6:0] seg_letter;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] code;
        logic [5:0] exp_dots;
    } vec_t;

    vec_t       vecs [12];
    logic [5:0] first_decade [9];

    braille_cell_player #(
        .DEPTH      (8),
        .SHOW_TICKS (2),
        .GAP_TICKS  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .letter     (letter),
        .clear      (clear),
        .dots       (dots),
        .busy       (busy),
        .full       (full),
        .err        (err),
        .seg_letter (seg_letter)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic push(input logic [4:0] code);
        load   = 1'b1;
        letter = code;
        step();
        load   = 1'b0;
    endtask

    // Waits (bounded) for a cell, checks it through show and gap, leaves the gap finished.
    task automatic play_expect(input string name, input logic [5:0] exp);
        int n;
        n = 0;
        while (dots == 6'b0 && n < 20) begin
            step();
            n++;
        end
        chk({name, " shown"}, 32'(dots), 32'(exp));
        pulse_tick();
        chk({name, " held"}, 32'(dots), 32'(exp));
        pulse_tick();
        chk({name, " gap"}, 32'(dots), 32'(0));
        pulse_tick();
    endtask

    initial begin
        bit seen;

        vecs[0]  = '{5'd0,  6'b000001};
        vecs[1]  = '{5'd2,  6'b001001};
        vecs[2]  = '{5'd4,  6'b010001};
        vecs[3]  = '{5'd6,  6'b011011};
        vecs[4]  = '{5'd9,  6'b011010};
        vecs[5]  = '{5'd15, 6'b001111};
        vecs[6]  = '{5'd19, 6'b011110};
        vecs[7]  = '{5'd20, 6'b100101};
        vecs[8]  = '{5'd21, 6'b100111};
        vecs[9]  = '{5'd23, 6'b101101};
        vecs[10] = '{5'd24, 6'b111101};
        vecs[11] = '{5'd25, 6'b110101};

        first_decade[0] = 6'b000001;
        first_decade[1] = 6'b000011;
        first_decade[2] = 6'b001001;
        first_decade[3] = 6'b011001;
        first_decade[4] = 6'b010001;
        first_decade[5] = 6'b001011;
        first_decade[6] = 6'b011011;
        first_decade[7] = 6'b010011;
        first_decade[8] = 6'b001010;

        rst    = 1'b1;
        tick   = 1'b0;
        load   = 1'b0;
        letter = 5'd0;
        clear  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset dots", 32'(dots), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset full", 32'(full), 32'(0));
        chk("reset err", 32'(err), 32'(0));
        chk("reset seg", 32'(seg_letter), 32'h7F);

        // Single letter 'c': latency, hold, gap, busy fall.
        push(5'd2);
        chk("c latency dots", 32'(dots), 32'(0));
        chk("c latency busy", 32'(busy), 32'(1));
        step();
        chk("c dots", 32'(dots), 32'b001001);
        pulse_tick();
        chk("c after 1 tick", 32'(dots), 32'b001001);
        pulse_tick();
        chk("c gap dots", 32'(dots), 32'(0));
        chk("c gap busy", 32'(busy), 32'(1));
        pulse_tick();
        chk("c busy after gap", 32'(busy), 32'(0));

        // Encoding table, one letter at a time.
        for (int i = 0; i < 12; i++) begin
            push(vecs[i].code);
            chk($sformatf("vec%0d latency", i), 32'(dots), 32'(0));
            step();
            chk($sformatf("vec%0d dots", i), 32'(dots), 32'(vecs[i].exp_dots));
            pulse_tick();
            chk($sformatf("vec%0d held", i), 32'(dots), 32'(vecs[i].exp_dots));
            pulse_tick();
            chk($sformatf("vec%0d gap", i), 32'(dots), 32'(0));
            pulse_tick();
            chk($sformatf("vec%0d idle busy", i), 32'(busy), 32'(0));
        end

        // Back-to-back k, w, z.
        push(5'd10);
        push(5'd22);
        push(5'd25);
        play_expect("k", 6'b000101);
        play_expect("w", 6'b111010);
        play_expect("z", 6'b110101);
        chk("kwz busy end", 32'(busy), 32'(0));

        // Fill until full with no ticks; first letter is popped, so the 10th is dropped.
        for (int i = 0; i < 10; i++) begin
            load   = 1'b1;
            letter = (i == 9) ? 5'd25 : 5'(i);
            step();
            chk($sformatf("fill%0d full", i), 32'(full), 32'(i >= 8));
            chk($sformatf("fill%0d err", i), 32'(err), 32'(i == 9));
        end
        load = 1'b0;
        step();
        chk("fill err cleared", 32'(err), 32'(0));
        chk("fill still full", 32'(full), 32'(1));
        for (int i = 0; i < 9; i++) begin
            play_expect($sformatf("fill play%0d", i), first_decade[i]);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dots != 6'b0) seen = 1'b1;
            step();
        end
        chk("dropped never plays", 32'(seen), 32'(0));
        chk("fill drained busy", 32'(busy), 32'(0));

        // Out-of-range codes.
        load   = 1'b1;
        letter = 5'd26;
        step();
        chk("code26 err", 32'(err), 32'(1));
        letter = 5'd31;
        step();
        chk("code31 err", 32'(err), 32'(1));
        chk("bad codes busy", 32'(busy), 32'(0));
        load = 1'b0;
        step();
        chk("bad codes err clear", 32'(err), 32'(0));
        step();
        chk("bad codes dots", 32'(dots), 32'(0));
        chk("bad codes busy later", 32'(busy), 32'(0));

        // Clear during SHOW with three queued.
        push(5'd1);
        push(5'd2);
        push(5'd3);
        push(5'd4);
        chk("pre-clear dots", 32'(dots), 32'b000011);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear dots", 32'(dots), 32'(0));
        chk("clear busy", 32'(busy), 32'(0));
        chk("clear full", 32'(full), 32'(0));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse_tick();
            if (dots != 6'b0 || busy) seen = 1'b1;
        end
        chk("clear nothing plays", 32'(seen), 32'(0));

        // Reset mid-GAP, with a bad load on the reset edge.
        push(5'd2);
        step();
        pulse_tick();
        pulse_tick();
        chk("mid-gap busy", 32'(busy), 32'(1));
        chk("mid-gap dots", 32'(dots), 32'(0));
        rst    = 1'b1;
        load   = 1'b1;
        letter = 5'd31;
        step();
        rst  = 1'b0;
        load = 1'b0;
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst err", 32'(err), 32'(0));
        chk("rst dots", 32'(dots), 32'(0));
        chk("rst seg", 32'(seg_letter), 32'h7F);

        // Load coincident with clear is discarded silently.
        clear  = 1'b1;
        load   = 1'b1;
        letter = 5'd3;
        step();
        clear = 1'b0;
        load  = 1'b0;
        chk("clear+load err", 32'(err), 32'(0));
        chk("clear+load busy", 32'(busy), 32'(0));
        step();
        step();
        chk("clear+load no play", 32'(dots), 32'(0));
        chk("clear+load busy later", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
